recon_mb_writer: RTL and testbench

Write-side counterpart of the luma 16x16 macroblock fetch path. It accepts a reconstructed 16x16 luma macroblock as a raster pixel stream and writes it into the prediction frame memory at the macroblock's position. It also keeps the neighbour buffers (a top line and a left column) that intra prediction reads. This lets top/left neighbours come from reconstructed data rather than the source image.

---
 rtl/recon_mb_writer.sv | 231 +++++++++++++++++++++++
 tb/tb_recon_mb_writer.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/recon_mb_writer.sv
// ----------------------------------------------------------------------------
// recon_mb_writer
//
// Writes a reconstructed 16x16 luma macroblock, delivered as a raster pixel
// stream, into the prediction frame memory at the macroblock's position. It
// also maintains the intra-prediction neighbour buffers: a top line (bottom
// row of every MB written) and a left column (right column of the last MB).
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   start, mbnumber     begin an MB write (sampled in IDLE only), raster MB
//   pix_valid/pix_data  reconstructed pixel stream, raster order within MB
//   pix_ready           high while the block accepts pixels
//   busy                high outside IDLE
//   done, err           one-cycle end-of-MB pulse; err = MB index out of range
//   mem_we/addr/wdata   frame memory write port (one cycle after accept)
//   nb_rd, nb_mbnumber, nb_idx   neighbour query (registered, 1-cycle latency)
//   nb_top, nb_left     neighbour pixels (128 at frame edges), held between reads
//
// Optional build macro RECON_CHECKSUM_EN adds mb_checksum: the modulo-2^16
// sum of the accepted pixels of the current MB, valid with done.
// ----------------------------------------------------------------------------
module recon_mb_writer #(
    parameter int unsigned LENGTH  = 1280,
    parameter int unsigned WIDTH   = 720,
    parameter int unsigned MB_SIZE = 16,
    parameter int unsigned ADDR_W  = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [12:0]       mbnumber,
    input  logic              pix_valid,
    input  logic [7:0]        pix_data,
    output logic              pix_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              nb_rd,
    input  logic [12:0]       nb_mbnumber,
    input  logic [3:0]        nb_idx,
    output logic [7:0]        nb_top,
    output logic [7:0]        nb_left
`ifdef RECON_CHECKSUM_EN
    ,
    output logic [15:0]       mb_checksum
`endif
);

    localparam int unsigned MBW = LENGTH / MB_SIZE;
    localparam int unsigned MBH = WIDTH / MB_SIZE;
    localparam int unsigned NMB = MBW * MBH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [3:0]        r_q, c_q, r_d, c_d;
    logic [6:0]        mb_x_q, mb_y_q;
    logic              mb_err_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q, addr_d;
    logic [7:0]        mem_wdata_q;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [7:0]        nb_top_q, nb_left_q;

    logic              start_acc;
    logic              in_range;
    logic              accept;
    logic              last_pix;
    logic [6:0]        start_x, start_y;
    logic [6:0]        nb_x, nb_y;

    // Neighbour storage is deliberately not reset.
    logic [7:0]        top_line [LENGTH];
    logic [7:0]        left_col [MB_SIZE];

    // ------------------------------------------------------------------
    // Decode helpers
    // ------------------------------------------------------------------
    always_comb begin
        in_range  = (mbnumber < 13'(NMB));
        start_acc = (state_q == S_IDLE) && start;
        accept    = pix_valid && pix_ready;
        last_pix  = (r_q == 4'd15) && (c_q == 4'd15);
        start_x   = 7'(mbnumber % 13'(MBW));
        start_y   = 7'(mbnumber / 13'(MBW));
        nb_x      = 7'(nb_mbnumber % 13'(MBW));
        nb_y      = 7'(nb_mbnumber / 13'(MBW));
        c_d       = c_q + 4'd1;
        r_d       = (c_q == 4'd15) ? r_q + 4'd1 : r_q;
        // With 16-pixel MBs, mb*16+offset is a plain concatenation.
        addr_d    = ADDR_W'({mb_y_q, r_q}) * ADDR_W'(LENGTH)
                  + ADDR_W'({mb_x_q, c_q});
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = in_range ? S_WRITE : S_DONE;
                end
            end
            S_WRITE: begin
                if (accept && last_pix) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. done/err are registered so the pulse lands one cycle
    // after the final memory write.
    // ------------------------------------------------------------------
    always_comb begin
        pix_ready = (state_q == S_WRITE);
        busy      = (state_q != S_IDLE);
        done_d    = (state_q == S_DONE);
        err_d     = (state_q == S_DONE) && mb_err_q;
    end

    // ------------------------------------------------------------------
    // Counters, write pipeline, neighbour read registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q         <= '0;
            c_q         <= '0;
            mb_x_q      <= '0;
            mb_y_q      <= '0;
            mb_err_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            nb_top_q    <= '0;
            nb_left_q   <= '0;
        end else begin
            done_q   <= done_d;
            err_q    <= err_d;
            mem_we_q <= accept;

            if (start_acc) begin
                r_q      <= '0;
                c_q      <= '0;
                mb_x_q   <= start_x;
                mb_y_q   <= start_y;
                mb_err_q <= !in_range;
            end else if (accept) begin
                r_q <= r_d;
                c_q <= c_d;
            end

            if (accept) begin
                mem_addr_q  <= addr_d;
                mem_wdata_q <= pix_data;
            end

            if (nb_rd) begin
                nb_top_q  <= (nb_y == 7'd0) ? 8'd128 : top_line[{nb_x, nb_idx}];
                nb_left_q <= (nb_x == 7'd0) ? 8'd128 : left_col[nb_idx];
            end
        end
    end

    // ------------------------------------------------------------------
    // Neighbour buffer updates
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (accept) begin
            if (r_q == 4'd15) begin
                top_line[{mb_x_q, c_q}] <= pix_data;
            end
            if (c_q == 4'd15) begin
                left_col[r_q] <= pix_data;
            end
        end
    end

`ifdef RECON_CHECKSUM_EN
    logic [15:0] sum_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q <= '0;
        end else if (start_acc) begin
            sum_q <= '0;
        end else if (accept) begin
            sum_q <= sum_q + 16'(pix_data);
        end
    end

    assign mb_checksum = sum_q;
`endif

    assign done      = done_q;
    assign err       = err_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign nb_top    = nb_top_q;
    assign nb_left   = nb_left_q;

endmodule

// File: tb/tb_recon_mb_writer.sv
module tb_recon_mb_writer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [12:0] mbnumber = '0;
    logic        pix_valid = 1'b0;
    logic [7:0]  pix_data = '0;
    logic        pix_ready;
    logic        busy;
    logic        done;
    logic        err;
    logic        mem_we;
    logic [19:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        nb_rd = 1'b0;
    logic [12:0] nb_mbnumber = '0;
    logic [3:0]  nb_idx = '0;
    logic [7:0]  nb_top;
    logic [7:0]  nb_left;
`ifdef RECON_CHECKSUM_EN
    logic [15:0] mb_checksum;
`endif

    recon_mb_writer #(
        .LENGTH (1280),
        .WIDTH  (720),
        .MB_SIZE(16),
        .ADDR_W (20)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mbnumber   (mbnumber),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .pix_ready  (pix_ready),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .nb_rd      (nb_rd),
        .nb_mbnumber(nb_mbnumber),
        .nb_idx     (nb_idx),
        .nb_top     (nb_top),
        .nb_left    (nb_left)
`ifdef RECON_CHECKSUM_EN
        ,
        .mb_checksum(mb_checksum)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Cycle counter changes only on posedge; everything reads it at negedge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Write/done log, sampled on the inactive edge.
    logic [19:0] wq_addr[$];
    logic [7:0]  wq_data[$];
    int          wq_cyc[$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    logic        done_err = 1'b0;
    logic [15:0] done_sum = '0;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wq_addr.push_back(mem_addr);
            wq_data.push_back(mem_wdata);
            wq_cyc.push_back(cyc);
        end
        if (done === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
            done_err = err;
`ifdef RECON_CHECKSUM_EN
            done_sum = mb_checksum;
`endif
        end
    end

    typedef struct {
        logic [12:0] mb;
        logic [3:0]  idx;
        logic [7:0]  top;
        logic [7:0]  left;
    } nbvec_t;

    nbvec_t vec[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pix(input int pat, input int k);
        case (pat)
            0:       return 8'(k);
            1:       return 8'(3 * k + 7);
            default: return 8'hFF;
        endcase
    endfunction

    task automatic clear_log();
        wq_addr.delete();
        wq_data.delete();
        wq_cyc.delete();
    endtask

    task automatic start_mb(input logic [12:0] mbn);
        @(negedge clk);
        start = 1'b1;
        mbnumber = mbn;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Presents npix pixels; optionally drops valid for 3 cycles once gap_at
    // pixels have been accepted, pulsing start during the gap.
    task automatic stream(input int pat, input int npix, input int gap_at, input bit mid_start);
        int k = 0;
        int gap = 0;
        int guard = 0;
        while (k < npix && guard < 2000) begin
            start = 1'b0;
            if (k == gap_at && gap < 3) begin
                pix_valid = 1'b0;
                gap++;
                if (mid_start && gap == 2) begin
                    start = 1'b1;
                    mbnumber = 13'd5;
                end
            end else if (pix_ready === 1'b1) begin
                pix_valid = 1'b1;
                pix_data = pix(pat, k);
                k++;
            end else begin
                pix_valid = 1'b0;
            end
            @(negedge clk);
            guard++;
        end
        pix_valid = 1'b0;
        start = 1'b0;
        chk("stream_accepts", k, npix);
    endtask

    task automatic query(input logic [12:0] mb, input logic [3:0] idx);
        @(negedge clk);
        nb_rd = 1'b1;
        nb_mbnumber = mb;
        nb_idx = idx;
        @(negedge clk);
        nb_rd = 1'b0;
    endtask

    task automatic check_mb(input string tag, input int mbn, input int pat, input int gap,
                            input int first_a, input int last_a, input int done_before);
        int bad = 0;
        int mx = mbn % 80;
        int my = mbn / 80;
        logic [15:0] sum = '0;
        repeat (4) @(negedge clk);
        chk({tag, "_writes"}, wq_addr.size(), 256);
        chk({tag, "_done_count"}, done_cnt - done_before, 1);
        chk({tag, "_err"}, done_err, 0);
        if (wq_addr.size() == 256) begin
            for (int k = 0; k < 256; k++) begin
                int ea = (my * 16 + k / 16) * 1280 + mx * 16 + k % 16;
                if (wq_addr[k] !== 20'(ea) || wq_data[k] !== pix(pat, k)) begin
                    if (bad < 4)
                        $display("  %s write %0d: addr %0d data %0d, want addr %0d data %0d",
                                 tag, k, wq_addr[k], wq_data[k], ea, pix(pat, k));
                    bad++;
                end
            end
            chk({tag, "_write_model"}, bad, 0);
            chk({tag, "_first_addr"}, wq_addr[0], first_a);
            chk({tag, "_last_addr"}, wq_addr[255], last_a);
            chk({tag, "_span"}, wq_cyc[255] - wq_cyc[0], 255 + gap);
            chk({tag, "_done_timing"}, done_cyc, wq_cyc[255] + 1);
        end
        for (int k = 0; k < 256; k++) sum = sum + 16'(pix(pat, k));
`ifdef RECON_CHECKSUM_EN
        chk({tag, "_checksum"}, done_sum, sum);
`endif
    endtask

    initial begin
        int d0;
        int c0;

        // Neighbour query vectors after MB 0 with pixel k = k.
        vec[0] = '{mb: 13'd1,   idx: 4'd3,  top: 8'd128, left: 8'd63};
        vec[1] = '{mb: 13'd80,  idx: 4'd5,  top: 8'd245, left: 8'd128};
        vec[2] = '{mb: 13'd1,   idx: 4'd0,  top: 8'd128, left: 8'd15};
        vec[3] = '{mb: 13'd80,  idx: 4'd15, top: 8'd255, left: 8'd128};
        vec[4] = '{mb: 13'd0,   idx: 4'd7,  top: 8'd128, left: 8'd128};
        vec[5] = '{mb: 13'd160, idx: 4'd0,  top: 8'd240, left: 8'd128};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_pix_ready", pix_ready, 0);
        chk("rst_nb_top", nb_top, 0);
        chk("rst_nb_left", nb_left, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // MB 0, pixel k = k, continuous
        d0 = done_cnt;
        clear_log();
        start_mb(13'd0);
        stream(0, 256, -1, 1'b0);
        check_mb("mb0", 0, 0, 0, 0, 19215, d0);
        if (wq_addr.size() == 256) begin
            chk("mb0_first_data", wq_data[0], 0);
            chk("mb0_addr_r1c0", wq_addr[16], 1280);
            chk("mb0_last_data", wq_data[255], 255);
        end

        // Neighbour queries
        for (int i = 0; i < 6; i++) begin
            query(vec[i].mb, vec[i].idx);
            chk($sformatf("nb_top_v%0d", i), nb_top, vec[i].top);
            chk($sformatf("nb_left_v%0d", i), nb_left, vec[i].left);
        end
        // Outputs hold while nb_rd is low
        @(negedge clk);
        nb_mbnumber = 13'd1;
        nb_idx = 4'd9;
        repeat (2) @(negedge clk);
        chk("nb_hold_top", nb_top, 240);
        chk("nb_hold_left", nb_left, 128);

        // MB 81 with stall after pixel 100 and a start pulse mid-MB
        d0 = done_cnt;
        clear_log();
        start_mb(13'd81);
        stream(1, 256, 101, 1'b1);
        check_mb("mb81", 81, 1, 3, 20496, 39711, d0);
        chk("mb81_idle_after", busy, 0);

        query(13'd161, 4'd4);
        chk("nb161_top", nb_top, 227);
        chk("nb161_left", nb_left, 244);
        query(13'd81, 4'd15);
        chk("nb81_top", nb_top, 4);
        chk("nb81_left", nb_left, 4);

        // Out-of-range MB
        d0 = done_cnt;
        clear_log();
        @(negedge clk);
        c0 = cyc;
        start = 1'b1;
        mbnumber = 13'd3600;
        @(negedge clk);
        start = 1'b0;
        chk("oor_busy", busy, 1);
        chk("oor_pix_ready", pix_ready, 0);
        repeat (4) @(negedge clk);
        chk("oor_done_count", done_cnt - d0, 1);
        chk("oor_done_timing", done_cyc, c0 + 2);
        chk("oor_err", done_err, 1);
        chk("oor_writes", wq_addr.size(), 0);
`ifdef RECON_CHECKSUM_EN
        chk("oor_checksum", done_sum, 0);
`endif

        // Last valid MB, all pixels 0xFF: maximum address
        d0 = done_cnt;
        clear_log();
        start_mb(13'd3599);
        stream(2, 256, -1, 1'b0);
        check_mb("mb3599", 3599, 2, 0, 902384, 921599, d0);

        // Reset after 50 pixels of MB 2
        d0 = done_cnt;
        clear_log();
        start_mb(13'd2);
        stream(0, 50, -1, 1'b0);
        #1 reset = 1'b1;
        #1;
        chk("mrst_busy", busy, 0);
        chk("mrst_pix_ready", pix_ready, 0);
        chk("mrst_mem_we", mem_we, 0);
        chk("mrst_nb_top", nb_top, 0);
`ifdef RECON_CHECKSUM_EN
        chk("mrst_checksum", mb_checksum, 0);
`endif
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("mrst_no_done", done_cnt - d0, 0);
        chk("mrst_writes", wq_addr.size(), 50);
        // Neighbour buffers survive reset
        query(13'd80, 4'd5);
        chk("mrst_nb_top_kept", nb_top, 245);
        chk("mrst_nb_left_edge", nb_left, 128);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound
    initial begin
        #2000000;
        $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
